// File: rtl/dma_periph_pkg.sv
// Shared types and constants for the DMA peripheral endpoint.
package dma_periph_pkg;

  localparam int DMA_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    RELEASE
  } state_e;

  typedef enum logic {
    DEV_TO_MEM,
    MEM_TO_DEV
  } dir_e;

endpackage : dma_periph_pkg

// File: rtl/dma_peripheral_endpoint_if.sv
// Shared DMA bus between the controller (master) and a peripheral endpoint (slave).
interface dma_peripheral_endpoint_if
  import dma_periph_pkg::*;
#(
  parameter int DATA_WIDTH = DMA_DATA_WIDTH
);

  logic                  DREQ;
  logic                  DACK;
  logic                  IOR_N;
  logic                  IOW_N;
  logic                  EOP_N;
  logic [DATA_WIDTH-1:0] DB_IN;
  logic [DATA_WIDTH-1:0] DB_OUT;
  logic                  DB_OE;

  modport master (
    input  DREQ, DB_OUT, DB_OE,
    output DACK, IOR_N, IOW_N, EOP_N, DB_IN
  );

  modport slave (
    output DREQ, DB_OUT, DB_OE,
    input  DACK, IOR_N, IOW_N, EOP_N, DB_IN
  );

endinterface : dma_peripheral_endpoint_if

// File: rtl/dma_peripheral_endpoint_sync_fifo.sv
// Single-clock FIFO with valid/ready on both sides and an occupancy count.
// A push and a pop in the same cycle are both honoured.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign count     = count_q;

  // Pointer and occupancy update for this cycle's push/pop.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write.
  // NOTE: storage is not reset; emptiness comes from count_q and out_data is gated, so stale words never show.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

endmodule : sync_fifo

// File: rtl/dma_peripheral_endpoint.sv
// Peripheral side of the DMA handshake: raises DREQ, answers DACK with one byte
// per I/O strobe, and buffers local data in a TX and an RX FIFO.
module dma_peripheral_endpoint
  import dma_periph_pkg::*;
#(
  parameter int DATA_WIDTH = DMA_DATA_WIDTH,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic                  DIR,
  input  logic                  DEMAND,
  input  logic                  START,
  dma_peripheral_endpoint_if.slave bus,
  input  logic                  TX_VALID,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_READY,
  output logic                  RX_VALID,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_READY,
  output logic                  TC_DONE,
  output logic                  ERR
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dir_e                  dir;
  state_e                state_q, state_d;
  logic                  dreq_q, dreq_d;
  logic                  dack_q, dack_d;
  logic                  ior_n_q, ior_n_d;
  logic                  iow_n_q, iow_n_d;
  logic [DATA_WIDTH-1:0] db_q, db_d;
  logic                  tc_done_q, tc_done_d;
  logic                  err_q, err_d;

  logic                  rd_done, wr_done, done, eop_hit, strobe_pending;
  logic                  tx_valid_out, rx_ready_in;
  logic                  tx_push, tx_pop, rx_push, rx_pop;
  logic [CW-1:0]         tx_count, rx_count, tx_after, rx_after;
  logic                  work_now, work_after;

  assign dir = dir_e'(DIR);

  // A strobe completes on its rising edge while the registered acknowledge is high;
  // only the strobe matching the current direction counts.
  assign rd_done = dack_q && !ior_n_q && bus.IOR_N && (dir == DEV_TO_MEM);
  assign wr_done = dack_q && !iow_n_q && bus.IOW_N && (dir == MEM_TO_DEV);
  assign done    = rd_done || wr_done;
  assign eop_hit = !bus.EOP_N && bus.DACK;
  assign strobe_pending = (dir == DEV_TO_MEM) ? !ior_n_q : !iow_n_q;

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .in_valid  (TX_VALID),
    .in_data   (TX_DATA),
    .in_ready  (TX_READY),
    .out_valid (tx_valid_out),
    .out_data  (bus.DB_OUT),
    .out_ready (rd_done),
    .count     (tx_count)
  );

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .in_valid  (wr_done),
    .in_data   (db_q),
    .in_ready  (rx_ready_in),
    .out_valid (RX_VALID),
    .out_data  (RX_DATA),
    .out_ready (RX_READY),
    .count     (rx_count)
  );

  // Bus drive is purely combinational so data is on the bus for the whole read strobe.
  assign bus.DB_OE = RESET_N && bus.DACK && !bus.IOR_N && (dir == DEV_TO_MEM);
  assign bus.DREQ  = dreq_q;
  assign TC_DONE   = tc_done_q;
  assign ERR       = err_q;

  // Work available now and after this cycle's FIFO traffic settles.
  always_comb begin
    tx_push  = TX_VALID && TX_READY;
    tx_pop   = rd_done && tx_valid_out;
    rx_push  = wr_done && rx_ready_in;
    rx_pop   = RX_VALID && RX_READY;
    tx_after = tx_count + CW'(tx_push) - CW'(tx_pop);
    rx_after = rx_count + CW'(rx_push) - CW'(rx_pop);
    if (dir == DEV_TO_MEM) begin
      work_now   = (tx_count != '0);
      work_after = (tx_after != '0);
    end else begin
      work_now   = (rx_count != CW'(FIFO_DEPTH));
      work_after = (rx_after != CW'(FIFO_DEPTH));
    end
  end

  // Request FSM next state, registered DREQ, and sticky flags.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ENABLE && work_now && !tc_done_q) state_d = REQ;
      REQ: begin
        if (bus.DACK)                  state_d = XFER;
        else if (!ENABLE || !work_now) state_d = IDLE;
      end
      XFER: begin
        if (done) begin
          if (!(DEMAND && ENABLE && work_after)) state_d = RELEASE;
        end else if (!bus.DACK && !strobe_pending) begin
          state_d = IDLE;
        end
      end
      RELEASE: if (!bus.DACK) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Terminal count overrides whatever the strobe decided this cycle.
    if (eop_hit) state_d = RELEASE;

    dreq_d = (state_d == REQ) || (state_d == XFER);

    tc_done_d = tc_done_q;
    err_d     = err_q;
    if (START && (state_q == IDLE)) begin
      tc_done_d = 1'b0;
      err_d     = 1'b0;
    end
    if (eop_hit) tc_done_d = 1'b1;
    if ((rd_done && !tx_valid_out) || (wr_done && !rx_ready_in)) err_d = 1'b1;
  end

  // Bus input sampling: strobe/acknowledge history and write-data capture.
  always_comb begin
    dack_d  = bus.DACK;
    ior_n_d = bus.IOR_N;
    iow_n_d = bus.IOW_N;
    db_d    = db_q;
    if (bus.DACK && !bus.IOW_N) db_d = bus.DB_IN;
  end

  // All endpoint state registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      dreq_q    <= 1'b0;
      dack_q    <= 1'b0;
      ior_n_q   <= 1'b1;
      iow_n_q   <= 1'b1;
      db_q      <= '0;
      tc_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dreq_q    <= dreq_d;
      dack_q    <= dack_d;
      ior_n_q   <= ior_n_d;
      iow_n_q   <= iow_n_d;
      db_q      <= db_d;
      tc_done_q <= tc_done_d;
      err_q     <= err_d;
    end
  end

endmodule : dma_peripheral_endpoint

// File: doc/dma_peripheral_endpoint.md
# dma_peripheral_endpoint

Peripheral-side endpoint of the DMA handshake: the device that raises DREQ, responds to DACK, and sources or sinks one byte per IOR_N/IOW_N strobe, with EOP_N ending the block. It sits on the shared bus opposite the DMA controller, one instance per channel. It buffers local-side data in small FIFOs. It is also the bus-functional responder used in controller-level simulation.

## Interface
- DATA_WIDTH, 8: DB width.
- FIFO_DEPTH, 8: depth of each FIFO; power of two, ≥2.
- CLK  in  1  bus clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  permits requesting.
- DIR  in  1  0 = device→memory (answers IOR_N), 1 = memory→device (answers IOW_N); change only while state is IDLE.
- DEMAND  in  1  0 = single mode, 1 = demand mode.
- START  in  1  one-cycle pulse; clears TC_DONE and ERR.
- DREQ  out  1  DMA request to controller.
- DACK  in  1  this channel's acknowledge, active high.
- IOR_N, IOW_N  in  1  bus I/O strobes, active low.
- EOP_N  in  1  terminal-count pulse from controller, active low.
- DB_IN  in  DATA_WIDTH  bus data in.
- DB_OUT  out  DATA_WIDTH  bus data out (TX FIFO head).
- DB_OE  out  1  bus drive enable.
- TX_VALID/TX_DATA/TX_READY  in/in/out  1/DATA_WIDTH/1  local push into TX FIFO.
- RX_VALID/RX_DATA/RX_READY  out/out/in  1/DATA_WIDTH/1  local pop from RX FIFO.
- TC_DONE  out  1  sticky: EOP seen.
- ERR  out  1  sticky: underrun or overrun.

## Operation
- work = DIR=0: TX count ≥1; DIR=1: RX free ≥1.
- States:
  - IDLE (DREQ=0): go to REQ when ENABLE & work & !TC_DONE.
  - REQ (DREQ=1): go to XFER on DACK; go to IDLE if !ENABLE or !work (checked only while DACK low).
  - XFER (DREQ=1): a completed strobe is a rising edge of the active strobe (registered low → input high) while the registered DACK is high.
    - On completion, single mode: go to RELEASE.
    - On completion, demand mode: stay in XFER if work remains after this transfer and ENABLE is high; otherwise go to RELEASE.
    - DACK low with no strobe pending: go to IDLE.
  - RELEASE (DREQ=0): go to IDLE when DACK is low.
- EOP_N sampled low while DACK is high sets TC_DONE and forces RELEASE, after any completing strobe in the same cycle.
- DIR=0 transfer:
  - DB_OE = DACK & !IOR_N & !DIR, purely combinational from inputs.
  - DB_OUT = TX head.
  - Pop on strobe completion.
  - Completion with TX empty: no pop, DB_OUT=0, ERR set.
- DIR=1 transfer:
  - DB_IN is registered every cycle that DACK & !IOW_N.
  - The last registered value is pushed on strobe completion.
  - Completion with RX full: value dropped, ERR set.
- Strobes with DACK low are ignored. The inactive-direction strobe is ignored.
- Local push and bus pop (or bus push and local pop) in the same cycle are both honoured. Counts stay exact.
- START is ignored unless state is IDLE.
- Reset, including mid-transfer, clears FIFOs, state and flags immediately.

## Timing
- Reset values: DREQ=0, DB_OE=0, DB_OUT=0, TX_READY=1, RX_VALID=0, RX_DATA=0, TC_DONE=0, ERR=0; state IDLE.
- DREQ is registered: it rises 1 cycle after the IDLE condition holds and falls 1 cycle after the terminating completion or EOP.
- DACK→XFER latency: 1 cycle.
- FIFO push→visible (TX_READY/RX_VALID update, DB_OUT head): 1 cycle.
- Single mode: minimum 1 IDLE cycle between requests, so DREQ is low for ≥2 cycles.
- Counts are $clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.

## Structure
- Package dma_periph_pkg:
  - state enum {IDLE, REQ, XFER, RELEASE};
  - direction enum {DEV_TO_MEM, MEM_TO_DEV};
  - DATA_WIDTH default constant.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; valid/ready both sides; count output), instantiated twice (TX and RX).
- The top level holds the FSM, the strobe edge detectors and the sticky flags.

## Test plan
- Single, DIR=0: push 0xA5, 0x3C; ENABLE=1 → DREQ rises.
  - DACK, then IOR_N low for 2 cycles → DB_OE=1 with DB_OUT=0xA5; pop on the IOR_N rise; DREQ falls.
  - The second request carries 0x3C.
- Demand, DIR=1, empty RX: four IOW_N strobes carrying 0x11..0x14 → DREQ stays high throughout; RX_DATA yields 0x11..0x14 in order.
- Fill RX with 8 entries in demand mode → DREQ drops after the 8th completion; one RX pop → DREQ reasserts after DACK falls.
- EOP_N low on the 3rd strobe → TC_DONE=1, DREQ=0, no further requests until START while IDLE.
- IOR_N strobe with TX empty → ERR=1, DB_OUT=0, count unchanged.
- RESET_N low mid-XFER → all outputs at reset values immediately, FIFOs empty.
